nrs_cmplx_mult_pipe: RTL and testbench

//  Pipelined, parametrised successor to the NB-IoT channel-estimation complex multiplier.

---
 rtl/nrs_cmplx_mult_pipe_if.sv | 38 +++
 rtl/nrs_cmplx_mult_pipe.sv | 167 ++++++++++++++++
 tb/tb_nrs_cmplx_mult_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrs_cmplx_mult_pipe_if.sv
// Streaming bundle for the NRS complex multiplier: sample input handshake,
// result output handshake, bank read port and the sticky saturation flag.
interface nrs_cmplx_mult_pipe_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 17,
  parameter int AW    = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] rx_r;
  logic signed [WIDTH-1:0] rx_i;
  logic                    nrs_r;
  logic                    nrs_i;
  logic                    mode;
  logic                    acc_en;
  logic [AW-1:0]           wr_addr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_r;
  logic signed [OUT_W-1:0] out_i;
  logic [AW-1:0]           out_addr;
  logic [AW-1:0]           rd_addr;
  logic signed [OUT_W-1:0] rd_r;
  logic signed [OUT_W-1:0] rd_i;
  logic                    sat_flag;

  modport master (
    output in_valid, rx_r, rx_i, nrs_r, nrs_i, mode, acc_en, wr_addr,
    output out_ready, rd_addr,
    input  in_ready, out_valid, out_r, out_i, out_addr, rd_r, rd_i, sat_flag
  );

  modport slave (
    input  in_valid, rx_r, rx_i, nrs_r, nrs_i, mode, acc_en, wr_addr,
    input  out_ready, rd_addr,
    output in_ready, out_valid, out_r, out_i, out_addr, rd_r, rd_i, sat_flag
  );
endinterface

// File: rtl/nrs_cmplx_mult_pipe.sv
// Pipelined rx * conj(NRS) / rx * NRS multiplier for NB-IoT channel
// estimation. Three register stages (sign-combine, coefficient product,
// round/accumulate/saturate) with a global stall, plus a DEPTH-entry
// result bank that can accumulate across NRS symbols.
module nrs_cmplx_mult_pipe #(
  parameter int WIDTH  = 16,
  parameter int OUT_W  = 17,
  parameter int COEF_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nrs_cmplx_mult_pipe_if.slave bus
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Two extra bits: |a*x + b*y| reaches 2^WIDTH when both inputs are full-scale negative.
  localparam int SW    = WIDTH + 2;
  localparam int PW    = SW + COEF_W;
  localparam int RW    = PW - (COEF_W - 1);
  localparam int ACC_W = ((RW > OUT_W) ? RW : OUT_W) + 1;

  // round(2^(cw-1)/sqrt2) == round(sqrt(2^(2cw-3))): largest c with c*c - c < 2^(2cw-3).
  function automatic int coef_calc(input int cw);
    longint n, c, t;
    n = longint'(1) << (2 * cw - 3);
    c = 0;
    for (int b = cw - 1; b >= 0; b--) begin
      t = c | (longint'(1) << b);
      if (t * t - t < n) c = t;
    end
    return int'(c);
  endfunction

  localparam logic signed [COEF_W-1:0] COEF    = COEF_W'(coef_calc(COEF_W));
  localparam logic signed [PW:0]       BIAS    = (PW + 1)'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(-(longint'(1) << (OUT_W - 1)));

  function automatic logic signed [RW-1:0] round_half_up(input logic signed [PW-1:0] p);
    logic signed [PW:0] t;
    t = (PW + 1)'(p) + BIAS;
    return RW'(t >>> (COEF_W - 1));
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return OUT_W'(SAT_MAX);
    if (v < SAT_MIN) return OUT_W'(SAT_MIN);
    return OUT_W'(v);
  endfunction

  function automatic logic clipped(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  logic                    stall;
  logic                    vld_p0_q, vld_p1_q, out_vld_q, sat_q;
  logic signed [SW-1:0]    xe, ye, ax, by, ay, bx, sr_p0_d, si_p0_d;
  logic signed [SW-1:0]    sr_p0_q, si_p0_q;
  logic                    acc_p0_q, acc_p1_q;
  logic [AW-1:0]           addr_p0_q, addr_p1_q;
  logic signed [PW-1:0]    pr_p1_q, pi_p1_q;
  logic signed [RW-1:0]    rr, ri;
  logic signed [OUT_W-1:0] base_r, base_i, out_r_d, out_i_d;
  logic signed [ACC_W-1:0] sum_r, sum_i;
  logic                    clip_d;
  logic signed [OUT_W-1:0] out_r_q, out_i_q, rd_r_q, rd_i_q;
  logic [AW-1:0]           out_addr_q;
  logic signed [OUT_W-1:0] bank_r_q [DEPTH];
  logic signed [OUT_W-1:0] bank_i_q [DEPTH];

  assign stall        = out_vld_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // S1 combine: apply NRS signs; mode selects conjugate or direct multiply.
  always_comb begin
    xe = SW'(bus.rx_r);
    ye = SW'(bus.rx_i);
    ax = bus.nrs_r ? -xe : xe;
    ay = bus.nrs_r ? -ye : ye;
    bx = bus.nrs_i ? -xe : xe;
    by = bus.nrs_i ? -ye : ye;
    if (bus.mode) begin
      sr_p0_d = ax - by;
      si_p0_d = ay + bx;
    end else begin
      sr_p0_d = ax + by;
      si_p0_d = ay - bx;
    end
  end

  // S3 combine: round, optionally add the old bank value, then clip.
  always_comb begin
    rr      = round_half_up(pr_p1_q);
    ri      = round_half_up(pi_p1_q);
    base_r  = acc_p1_q ? bank_r_q[addr_p1_q] : '0;
    base_i  = acc_p1_q ? bank_i_q[addr_p1_q] : '0;
    sum_r   = ACC_W'(rr) + ACC_W'(base_r);
    sum_i   = ACC_W'(ri) + ACC_W'(base_i);
    out_r_d = saturate(sum_r);
    out_i_d = saturate(sum_i);
    clip_d  = clipped(sum_r) | clipped(sum_i);
  end

  // Valid chain and sticky saturation flag; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      out_vld_q <= 1'b0;
      sat_q     <= 1'b0;
    end else if (!stall) begin
      vld_p0_q  <= bus.in_valid;
      vld_p1_q  <= vld_p0_q;
      out_vld_q <= vld_p1_q;
      if (vld_p1_q && clip_d) sat_q <= 1'b1;
    end
  end

  // ---- stage p0 -> p1 boundary: sign-combined sums into exact products ----
  always_ff @(posedge clk) begin
    if (!stall && bus.in_valid) begin
      sr_p0_q   <= sr_p0_d;
      si_p0_q   <= si_p0_d;
      acc_p0_q  <= bus.acc_en;
      addr_p0_q <= bus.wr_addr;
    end
    if (!stall && vld_p0_q) begin
      pr_p1_q   <= PW'(sr_p0_q) * PW'(COEF);
      pi_p1_q   <= PW'(si_p0_q) * PW'(COEF);
      acc_p1_q  <= acc_p0_q;
      addr_p1_q <= addr_p0_q;
    end
  end

  // ---- stage p1 -> output boundary: result register, bank write, bank read port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r_q    <= '0;
      out_i_q    <= '0;
      out_addr_q <= '0;
      rd_r_q     <= '0;
      rd_i_q     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        bank_r_q[k] <= '0;
        bank_i_q[k] <= '0;
      end
    end else begin
      rd_r_q <= bank_r_q[bus.rd_addr];
      rd_i_q <= bank_i_q[bus.rd_addr];
      if (!stall && vld_p1_q) begin
        out_r_q             <= out_r_d;
        out_i_q             <= out_i_d;
        out_addr_q          <= addr_p1_q;
        bank_r_q[addr_p1_q] <= out_r_d;
        bank_i_q[addr_p1_q] <= out_i_d;
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.rd_r      = rd_r_q;
  assign bus.rd_i      = rd_i_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_nrs_cmplx_mult_pipe.sv
// Bench for nrs_cmplx_mult_pipe: fixed vectors, directed pipeline corner
// sequences, and a long random valid/ready run against an arithmetic model.
module tb_nrs_cmplx_mult_pipe;
  localparam int WIDTH = 16, OUT_W = 17, COEF_W = 12, DEPTH = 4, AW = 2;
  localparam longint COEF = 1448;
  localparam longint OMAX = 65535, OMIN = -65536;
  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nrs_cmplx_mult_pipe_if #(.WIDTH(WIDTH), .OUT_W(OUT_W), .AW(AW)) bus();
  nrs_cmplx_mult_pipe #(.WIDTH(WIDTH), .OUT_W(OUT_W), .COEF_W(COEF_W), .DEPTH(DEPTH))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;
  int n_acc, n_out, got, cyc;
  bit iv, msat;
  longint mbank_r [DEPTH], mbank_i [DEPTH];

  typedef struct { longint r; longint i; int addr; } res_t;
  res_t expq [$];

  typedef struct {
    longint xr; longint xi; bit nr; bit ni; bit md; bit ac; int ad;
    longint er; longint ei; bit es;
  } vec_t;
  vec_t tbl [12];

  longint acc_er [3] = '{1414, 2121, 2828};
  longint rd_er  [4] = '{0, 707, 65535, -1};
  longint rd_ei  [4] = '{0, -707, 0, -46335};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // floor(s*COEF/2048 + 1/2)
  function automatic longint rnd(input longint s);
    return (s * COEF + 1024) >>> 11;
  endfunction

  function automatic longint clamp(input longint v);
    return (v > OMAX) ? OMAX : (v < OMIN) ? OMIN : v;
  endfunction

  task automatic model_accept(input longint x, input longint y, input bit nr, input bit ni,
                              input bit md, input bit ac, input int ad);
    longint a, b, sr, si, vr, vi;
    res_t e;
    a = nr ? -1 : 1;
    b = ni ? -1 : 1;
    if (!md) begin sr = a * x + b * y; si = a * y - b * x; end
    else     begin sr = a * x - b * y; si = a * y + b * x; end
    vr = rnd(sr) + (ac ? mbank_r[ad] : 0);
    vi = rnd(si) + (ac ? mbank_i[ad] : 0);
    if (vr != clamp(vr) || vi != clamp(vi)) msat = 1'b1;
    vr = clamp(vr);
    vi = clamp(vi);
    mbank_r[ad] = vr;
    mbank_i[ad] = vi;
    e.r = vr; e.i = vi; e.addr = ad;
    expq.push_back(e);
  endtask

  task automatic drive(input bit v, input longint x, input longint y, input bit nr, input bit ni,
                       input bit md, input bit ac, input int ad, input bit ordy);
    bus.in_valid  = v;
    bus.rx_r      = WIDTH'(x);
    bus.rx_i      = WIDTH'(y);
    bus.nrs_r     = nr;
    bus.nrs_i     = ni;
    bus.mode      = md;
    bus.acc_en    = ac;
    bus.wr_addr   = AW'(ad);
    bus.out_ready = ordy;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ordy);
  endtask

  // Called #1 after inputs change: scores the transfers the next edge will perform.
  task automatic sb_eval(input string tag);
    res_t e;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s_extra actual=unexpected_result required=none", tag);
      end else begin
        e = expq.pop_front();
        chk({tag, "_r"}, bus.out_r, e.r);
        chk({tag, "_i"}, bus.out_i, e.i);
        chk({tag, "_addr"}, bus.out_addr, e.addr);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      n_acc++;
      model_accept(bus.rx_r, bus.rx_i, bus.nrs_r, bus.nrs_i, bus.mode, bus.acc_en, int'(bus.wr_addr));
    end
  endtask

  task automatic rd_check(input string tag, input int a, input longint er, input longint ei);
    @(negedge clk);
    bus.rd_addr = AW'(a);
    @(negedge clk);
    #1;
    chk($sformatf("%s_rd%0d_r", tag, a), bus.rd_r, er);
    chk($sformatf("%s_rd%0d_i", tag, a), bus.rd_i, ei);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1000, 0, 0, 0, 0, 0, 1, 707, -707, 0};
    tbl[1]  = '{-32768, -32768, 1, 1, 0, 0, 2, 46336, 0, 0};
    tbl[2]  = '{-32768, -32768, 1, 1, 0, 1, 2, 65535, 0, 1};
    tbl[3]  = '{500, 300, 0, 0, 0, 0, 3, 566, -141, 1};
    tbl[4]  = '{500, 300, 0, 1, 0, 0, 3, 141, 566, 1};
    tbl[5]  = '{500, 300, 1, 0, 0, 0, 3, -141, -566, 1};
    tbl[6]  = '{500, 300, 1, 1, 0, 0, 3, -566, 141, 1};
    tbl[7]  = '{500, 300, 0, 0, 1, 0, 3, 141, 566, 1};
    tbl[8]  = '{500, 300, 0, 1, 1, 0, 3, 566, -141, 1};
    tbl[9]  = '{500, 300, 1, 0, 1, 0, 3, -566, 141, 1};
    tbl[10] = '{500, 300, 1, 1, 1, 0, 3, -141, -566, 1};
    tbl[11] = '{32767, -32768, 0, 0, 0, 0, 3, -1, -46335, 1};

    rst = 1'b1;
    idle(1'b1);
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_rd_r", bus.rd_r, 0);

    // Fixed vectors, one at a time, with exact latency.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive(1'b1, tbl[v].xr, tbl[v].xi, tbl[v].nr, tbl[v].ni, tbl[v].md, tbl[v].ac, tbl[v].ad, 1'b1);
      #1;
      chk($sformatf("tbl%0d_in_ready", v), bus.in_ready, 1);
      @(negedge clk);
      idle(1'b1);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_early_valid", v), bus.out_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", v), bus.out_valid, 1);
      chk($sformatf("tbl%0d_r", v), bus.out_r, tbl[v].er);
      chk($sformatf("tbl%0d_i", v), bus.out_i, tbl[v].ei);
      chk($sformatf("tbl%0d_addr", v), bus.out_addr, tbl[v].ad);
      chk($sformatf("tbl%0d_sat", v), bus.sat_flag, tbl[v].es);
    end
    for (int a = 1; a < 4; a++) rd_check("tbl", a, rd_er[a], rd_ei[a]);

    // Read of the address being written on the same edge returns the old value.
    @(negedge clk);
    bus.rd_addr = 2'd0;
    drive(1'b1, 1000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk); idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rdw_out_r", bus.out_r, 707);
    chk("rdw_old_r", bus.rd_r, 0);
    @(negedge clk);
    #1;
    chk("rdw_new_r", bus.rd_r, 707);
    chk("rdw_new_i", bus.rd_i, -707);

    // Back-to-back accumulation into address 0 (holding 707,-707).
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b1, 1000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      else idle(1'b1);
      #1;
      if (bus.out_valid && got < 3) begin
        chk($sformatf("b2b%0d_r", got), bus.out_r, acc_er[got]);
        chk($sformatf("b2b%0d_i", got), bus.out_i, -acc_er[got]);
        got++;
      end
    end
    chk("b2b_count", got, 3);

    // Backpressure: a stalled output lets exactly three samples in.
    n_acc = 0; n_out = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1'b1, 100 * (c + 1), -37 * (c + 1), bit'(c & 1), bit'((c >> 1) & 1), bit'(c > 2), 1'b0, c % 4, 1'b0);
      #1;
      sb_eval("bp");
    end
    chk("bp_accepted", n_acc, 3);
    chk("bp_in_ready", bus.in_ready, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle(1'b1);
      #1;
      sb_eval("bp");
    end
    chk("bp_outputs", n_out, 3);
    chk("bp_left", expq.size(), 0);

    // Reset with samples in flight.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 1234, -777, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
      #1;
      sb_eval("pre");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sat", bus.sat_flag, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    expq.delete();
    msat = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin mbank_r[a] = 0; mbank_i[a] = 0; end
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) got++;
    end
    chk("mid_rst_flushed", got, 0);
    for (int a = 0; a < DEPTH; a++) rd_check("mid_rst", a, 0, 0);

    // Random traffic with random backpressure.
    n_acc = 0; n_out = 0; cyc = 0;
    while ((n_acc < NRAND || expq.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      iv = (n_acc < NRAND) && ($urandom_range(3) != 0);
      drive(iv,
            ($urandom_range(7) == 0) ? -32768 : longint'($urandom_range(65535)) - 32768,
            ($urandom_range(7) == 0) ? 32767  : longint'($urandom_range(65535)) - 32768,
            bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)),
            bit'($urandom_range(1)), int'($urandom_range(3)), $urandom_range(3) != 0);
      bus.rd_addr = AW'($urandom_range(3));
      #1;
      chk("rnd_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      sb_eval("rnd");
      cyc++;
    end
    chk("rnd_sent", n_acc, NRAND);
    chk("rnd_drained", expq.size(), 0);
    @(negedge clk);
    idle(1'b1);
    #1;
    chk("rnd_sat", bus.sat_flag, msat);
    for (int a = 0; a < DEPTH; a++) rd_check("rnd_bank", a, mbank_r[a], mbank_i[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
